// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared opcode, forwarding-select and tracker-entry types for issue control
package issue_ctrl_pkg;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011
   } opcode_type_e;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   // valid is only set for instructions that really write a non-zero rd
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
   } trk_entry_t;

   function automatic logic reads_rs1(input logic [6:0] op);
      case (op)
         OP_JALR, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_REG: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic reads_rs2(input logic [6:0] op);
      case (op)
         OP_STORE, OP_BRANCH, OP_REG: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/issue_rd_tracker.sv
// rtl/issue_rd_tracker.sv - three-stage in-flight destination tracker (EX, MEM, WB) with source match outputs
module issue_rd_tracker
   import issue_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_i,
   input  trk_entry_t entry_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   output logic [2:0] rs1_hit_o,
   output logic [2:0] rs2_hit_o,
   output logic       ex_is_load_o
);

   trk_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;

   // Shift every cycle; EX takes the issued instruction or a bubble when nothing issues
   always_comb begin
      ex_d  = '0;
      mem_d = ex_q;
      wb_d  = mem_q;
      if (issue_i) begin
         ex_d = entry_i;
      end
   end

   // Stage registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // Per-stage source matches, bit 0 = EX, 1 = MEM, 2 = WB; x0 never has a valid entry
   always_comb begin
      rs1_hit_o    = {wb_q.valid  && (wb_q.rd  == rs1_i),
                      mem_q.valid && (mem_q.rd == rs1_i),
                      ex_q.valid  && (ex_q.rd  == rs1_i)};
      rs2_hit_o    = {wb_q.valid  && (wb_q.rd  == rs2_i),
                      mem_q.valid && (mem_q.rd == rs2_i),
                      ex_q.valid  && (ex_q.rd  == rs2_i)};
      ex_is_load_o = ex_q.valid && ex_q.is_load;
   end

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - ID issue control: RAW stall, redirect flush FSM, operand forwarding (ISSUE_FORWARD_EN)
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid_i,
   input  logic [31:0] id_instr_i,
   input  logic        redirect_i,
   output logic        id_ready_o,
   output logic        ex_valid_o,
   output logic        flush_o,
   output logic [1:0]  fwd_a_o,
   output logic [1:0]  fwd_b_o,
   output logic [31:0] stall_cnt_o
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

   typedef enum logic {ST_RUN, ST_FLUSH} state_e;

   state_e      state_q, state_d;
   logic [1:0]  fcnt_q, fcnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic        use_rs1, use_rs2;
   logic        hazard, stall, flush;
   logic [2:0]  rs1_hit, rs2_hit;
   logic        ex_is_load;
   fwd_sel_e    fwd_a, fwd_b;
   trk_entry_t  id_entry;
   logic        unused_bits;

   // Decode the IF/ID instruction into sources read and destination written
   always_comb begin
      opcode           = id_instr_i[6:0];
      rd               = id_instr_i[11:7];
      rs1              = id_instr_i[19:15];
      rs2              = id_instr_i[24:20];
      use_rs1          = reads_rs1(opcode);
      use_rs2          = reads_rs2(opcode);
      id_entry.valid   = writes_rd(opcode) && (rd != 5'd0);
      id_entry.rd      = rd;
      id_entry.is_load = (opcode == OP_LOAD);
   end

   issue_rd_tracker u_tracker (
      .clk          (clk),
      .rst          (rst),
      .issue_i      (ex_valid_o),
      .entry_i      (id_entry),
      .rs1_i        (rs1),
      .rs2_i        (rs2),
      .rs1_hit_o    (rs1_hit),
      .rs2_hit_o    (rs2_hit),
      .ex_is_load_o (ex_is_load)
   );

   // Hazard detection and operand select; WB never matters since the regfile is write-first
   always_comb begin
      hazard = 1'b0;
      fwd_a  = FWD_RF;
      fwd_b  = FWD_RF;
`ifdef ISSUE_FORWARD_EN
      hazard = ex_is_load && ((use_rs1 && rs1_hit[0]) || (use_rs2 && rs2_hit[0]));
      if (use_rs1) begin
         if (rs1_hit[0])      fwd_a = FWD_EXMEM;
         else if (rs1_hit[1]) fwd_a = FWD_MEMWB;
      end
      if (use_rs2) begin
         if (rs2_hit[0])      fwd_b = FWD_EXMEM;
         else if (rs2_hit[1]) fwd_b = FWD_MEMWB;
      end
`else
      hazard = (use_rs1 && (|rs1_hit[1:0])) || (use_rs2 && (|rs2_hit[1:0]));
`endif
   end

   // Flush FSM next state, stall decision and stall counter; a redirect overrides any stall
   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      flush       = 1'b0;
      stall       = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (redirect_i) begin
               flush = 1'b1;
               if (FLUSH_CYCLES != 0) begin
                  state_d = ST_FLUSH;
                  fcnt_d  = FLUSH_LOAD;
               end
            end else begin
               stall = id_valid_i && hazard;
            end
         end
         ST_FLUSH: begin
            flush = 1'b1;
            if (redirect_i) begin
               fcnt_d = FLUSH_LOAD;
            end else if (fcnt_q <= 2'd1) begin
               state_d = ST_RUN;
               fcnt_d  = 2'd0;
            end else begin
               fcnt_d = fcnt_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            fcnt_d  = 2'd0;
         end
      endcase
      stall_cnt_d = stall_cnt_q + 32'(stall);
   end

   // State, flush counter and stall counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         fcnt_q      <= 2'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign id_ready_o  = !stall;
   assign ex_valid_o  = id_valid_i && !stall && !flush;
   assign flush_o     = flush;
   assign fwd_a_o     = fwd_a;
   assign fwd_b_o     = fwd_b;
   assign stall_cnt_o = stall_cnt_q;

   // funct fields, WB matches and (without bypassing) the load flag play no part in issue
   assign unused_bits = ^{id_instr_i[31:25], id_instr_i[14:12], rs1_hit[2], rs2_hit[2], ex_is_load};

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - self-checking bench for issue_ctrl, default build or ISSUE_FORWARD_EN
module tb_issue_ctrl;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
   localparam logic [6:0] BR = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011, IMM = 7'b0010011;
   localparam logic [6:0] REG = 7'b0110011, BAD = 7'b1111111;
   localparam logic [6:0] OPS [10] = '{LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, IMM, REG, BAD};
   localparam int FC = 1;
`ifdef ISSUE_FORWARD_EN
   localparam logic [6:0] PROD = LOAD;
`else
   localparam logic [6:0] PROD = IMM;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid_i = 1'b0;
   logic [31:0] id_instr_i = 32'd0;
   logic        redirect_i = 1'b0;
   logic        ready, exv, flush;
   logic [1:0]  fa, fb;
   logic [31:0] scnt;
   logic        ready2, exv2, flush2;
   logic [1:0]  fa2, fb2;
   logic [31:0] scnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   issue_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_instr_i(id_instr_i), .redirect_i(redirect_i),
      .id_ready_o(ready), .ex_valid_o(exv), .flush_o(flush), .fwd_a_o(fa), .fwd_b_o(fb), .stall_cnt_o(scnt)
   );

   issue_ctrl #(.FLUSH_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_instr_i(id_instr_i), .redirect_i(redirect_i),
      .id_ready_o(ready2), .ex_valid_o(exv2), .flush_o(flush2), .fwd_a_o(fa2), .fwd_b_o(fb2), .stall_cnt_o(scnt2)
   );

   // Reference model: history of what issued in the last three cycles (age 0 = now in EX)
   typedef struct {bit v; int rd; bit ld;} ent_t;
   ent_t        hist [3];
   int          flush_left;
   logic [31:0] m_cnt;
   bit          m_v, m_redir;
   logic [31:0] m_instr;
   logic        e_ready, e_exv, e_flush;
   logic [1:0]  e_fa, e_fb;

   function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
   endfunction

   function automatic int age_of(input int r);
      if (r == 0) return -1;
      for (int a = 0; a < 3; a++) if (hist[a].v && hist[a].rd == r) return a;
      return -1;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 3; a++) hist[a] = '{0, 0, 0};
      flush_left = 0;
      m_cnt = 32'd0;
   endtask

   task automatic model_eval();
      logic [6:0] op;
      int s1, s2, a1, a2;
      bit hz;
      op = m_instr[6:0];
      s1 = (op inside {JALR, LOAD, IMM, STORE, BR, REG}) ? int'(m_instr[19:15]) : 0;
      s2 = (op inside {STORE, BR, REG}) ? int'(m_instr[24:20]) : 0;
      a1 = age_of(s1);
      a2 = age_of(s2);
`ifdef ISSUE_FORWARD_EN
      hz   = hist[0].ld && (a1 == 0 || a2 == 0);
      e_fa = (a1 == 0) ? 2'b01 : (a1 == 1) ? 2'b10 : 2'b00;
      e_fb = (a2 == 0) ? 2'b01 : (a2 == 1) ? 2'b10 : 2'b00;
`else
      hz   = (a1 == 0) || (a1 == 1) || (a2 == 0) || (a2 == 1);
      e_fa = 2'b00;
      e_fb = 2'b00;
`endif
      e_flush = m_redir || (flush_left > 0);
      if (e_flush) begin
         e_ready = 1'b1;
         e_exv   = 1'b0;
      end else begin
         e_ready = !(m_v && hz);
         e_exv   = m_v && !hz;
      end
   endtask

   task automatic model_commit();
      logic [6:0] op;
      op = m_instr[6:0];
      if (m_v && !e_ready) m_cnt = m_cnt + 32'd1;
      flush_left = m_redir ? FC : (flush_left > 0 ? flush_left - 1 : 0);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0].v  = e_exv && (op inside {LUI, AUIPC, JAL, JALR, LOAD, IMM, REG}) && (m_instr[11:7] != 5'd0);
      hist[0].rd = int'(m_instr[11:7]);
      hist[0].ld = (op == LOAD);
   endtask

   task automatic drive(input bit v, input logic [31:0] ins, input bit redir);
      id_valid_i = v;
      id_instr_i = ins;
      redirect_i = redir;
      m_v = v;
      m_instr = ins;
      m_redir = redir;
      #1;
      model_eval();
   endtask

   task automatic advance();
      model_commit();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      id_valid_i = 1'b0;
      redirect_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      drive(1, enc(LUI, 9, 0, 0), 0);
      checks++;
      if ({ready, exv, flush, fa, fb} !== 7'b1100000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", {ready, exv, flush, fa, fb}, 7'b1100000);
      end
      checks++;
      if (scnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_stall_cnt: got %0d expected 0", scnt);
      end
      drive(0, enc(LUI, 9, 0, 0), 0);
      checks++;
      if ({ready, exv, flush2} !== 3'b100) begin
         errors++;
         $display("FAIL reset_idle: got %b expected 100", {ready, exv, flush2});
      end
      advance();
   endtask

`ifdef ISSUE_FORWARD_EN
   task automatic test_load_use();
      do_reset();
      drive(1, enc(LOAD, 5, 1, 0), 0);
      advance();
      drive(1, enc(REG, 6, 5, 2), 0);
      checks++;
      if ({ready, exv} !== 2'b00) begin
         errors++;
         $display("FAIL load_use_stall: got %b expected 00", {ready, exv});
      end
      advance();
      drive(1, enc(REG, 6, 5, 2), 0);
      checks++;
      if ({ready, exv, fa} !== 4'b1110) begin
         errors++;
         $display("FAIL load_use_issue: got %b expected 1110", {ready, exv, fa});
      end
      advance();
      checks++;
      if (scnt !== 32'd1) begin
         errors++;
         $display("FAIL load_use_cnt: got %0d expected 1", scnt);
      end
   endtask

   task automatic test_forward();
      do_reset();
      drive(1, enc(IMM, 5, 0, 0), 0);
      advance();
      drive(1, enc(REG, 7, 3, 5), 0);
      checks++;
      if ({ready, exv, fa, fb} !== 6'b110001) begin
         errors++;
         $display("FAIL fwd_exmem: got %b expected 110001", {ready, exv, fa, fb});
      end
      advance();
      drive(1, enc(REG, 8, 5, 0), 0);
      checks++;
      if ({ready, exv, fa, fb} !== 6'b111000) begin
         errors++;
         $display("FAIL fwd_memwb: got %b expected 111000", {ready, exv, fa, fb});
      end
      advance();
   endtask
`else
   task automatic test_raw_stall();
      do_reset();
      drive(1, enc(IMM, 5, 0, 0), 0);
      advance();
      for (int c = 0; c < 3; c++) begin
         drive(1, enc(REG, 6, 5, 5), 0);
         checks++;
         if ({ready, exv, fa, fb} !== ((c < 2) ? 6'b000000 : 6'b110000)) begin
            errors++;
            $display("FAIL raw_stall_cycle%0d: got %b expected %b", c, {ready, exv, fa, fb},
                     (c < 2) ? 6'b000000 : 6'b110000);
         end
         advance();
      end
      checks++;
      if (scnt !== 32'd2) begin
         errors++;
         $display("FAIL raw_stall_cnt: got %0d expected 2", scnt);
      end
      drive(1, enc(IMM, 0, 0, 0), 0);
      advance();
      drive(1, enc(REG, 6, 0, 0), 0);
      checks++;
      if ({ready, exv} !== 2'b11) begin
         errors++;
         $display("FAIL x0_no_stall: got %b expected 11", {ready, exv});
      end
      advance();
   endtask
`endif

   task automatic test_redirect_stall();
      do_reset();
      drive(1, enc(PROD, 5, 1, 0), 0);
      advance();
      drive(1, enc(REG, 6, 5, 5), 1);
      checks++;
      if ({ready, exv, flush} !== 3'b101) begin
         errors++;
         $display("FAIL redirect_over_stall: got %b expected 101", {ready, exv, flush});
      end
      advance();
      drive(1, enc(LUI, 9, 0, 0), 0);
      checks++;
      if ({ready, exv, flush, flush2} !== 4'b1011) begin
         errors++;
         $display("FAIL flush_hold: got %b expected 1011", {ready, exv, flush, flush2});
      end
      advance();
      drive(1, enc(LUI, 9, 0, 0), 0);
      checks++;
      if ({ready, exv, flush, flush2} !== 4'b1101) begin
         errors++;
         $display("FAIL flush_release: got %b expected 1101", {ready, exv, flush, flush2});
      end
      checks++;
      if (scnt !== 32'd0) begin
         errors++;
         $display("FAIL redirect_not_counted: got %0d expected 0", scnt);
      end
      advance();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(1, enc(PROD, 5, 1, 0), 0);
      advance();
      drive(1, enc(REG, 6, 5, 5), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      drive(1, enc(REG, 6, 5, 5), 0);
      checks++;
      if ({ready, exv, flush, fa, fb} !== 7'b1100000 || scnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_stall: got %b cnt %0d expected 1100000 cnt 0", {ready, exv, flush, fa, fb}, scnt);
      end
      advance();
   endtask

   task automatic test_reset_in_flush();
      do_reset();
      drive(1, enc(PROD, 5, 1, 0), 0);
      advance();
      drive(1, enc(REG, 6, 5, 5), 0);
      advance();
      drive(1, enc(LUI, 9, 0, 0), 1);
      advance();
      drive(1, enc(LUI, 9, 0, 0), 0);
      checks++;
      if (flush2 !== 1'b1 || scnt2 === 32'd0) begin
         errors++;
         $display("FAIL flush2_entry: got flush %b cnt %0d expected flush 1 cnt nonzero", flush2, scnt2);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      drive(1, enc(REG, 6, 5, 5), 0);
      checks++;
      if ({ready2, exv2, flush2, fa2, fb2} !== 7'b1100000 || scnt2 !== 32'd0) begin
         errors++;
         $display("FAIL reset_in_flush: got %b cnt %0d expected 1100000 cnt 0", {ready2, exv2, flush2, fa2, fb2}, scnt2);
      end
      advance();
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1, enc(PROD, 5, 1, 0), 0);
      advance();
      drive(1, enc(REG, 6, 5, 2), 0);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      advance();
      checks++;
      if (scnt !== 32'd0) begin
         errors++;
         $display("FAIL stall_cnt_wrap: got %0h expected 0", scnt);
      end
      do_reset();
   endtask

   task automatic test_random();
      logic [31:0] ins;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         ins = enc(OPS[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         ins[31:25] = 7'($urandom);
         ins[14:12] = 3'($urandom);
         drive($urandom_range(0, 9) < 8, ins, $urandom_range(0, 11) == 0);
         checks++;
         if ({ready, exv, flush, fa, fb} !== {e_ready, e_exv, e_flush, e_fa, e_fb}) begin
            errors++;
            $display("FAIL random_outputs cycle %0d instr %h: got %b expected %b", i, ins,
                     {ready, exv, flush, fa, fb}, {e_ready, e_exv, e_flush, e_fa, e_fb});
         end
         checks++;
         if (scnt !== m_cnt) begin
            errors++;
            $display("FAIL random_stall_cnt cycle %0d: got %0d expected %0d", i, scnt, m_cnt);
         end
         advance();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
`ifdef ISSUE_FORWARD_EN
      test_load_use();
      test_forward();
`else
      test_raw_stall();
`endif
      test_redirect_stall();
      test_reset_mid_stall();
      test_reset_in_flush();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
